// File: rtl/shift_reg_univ.sv
// ----------------------------------------------------------------------------
// shift_reg_univ
//
// Universal shift register with a counted burst engine.
// Each enabled clock edge can hold, shift left, shift right (logical or
// arithmetic), rotate in either direction, load in parallel or clear. The bit
// that leaves the register on a shift or rotate is kept in sout. A start
// command performs len consecutive shifts or rotates. busy is high while the
// burst runs, and done pulses for one cycle when the burst finishes.
//
// Ports
//   clk    : system clock, rising edge
//   rst    : asynchronous, active-high reset
//   en     : clock enable (done still clears when en is low)
//   mode   : operation select (see localparams below)
//   din_l  : serial bit entering at the MSB on a logical right shift
//   din_r  : serial bit entering at the LSB on a left shift
//   pdata  : parallel load data
//   start  : burst request, accepted only when idle and enabled
//   len    : burst length (0 gives only a done pulse)
//   q      : register contents
//   sout   : bit shifted or rotated out most recently
//   busy   : burst in progress
//   done   : one-cycle burst completion pulse
// ----------------------------------------------------------------------------
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             din_l,
    input  logic             din_r,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_LSR  = 3'b010;
    localparam logic [2:0] M_ASR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_LOAD = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       lmode_q, lmode_d;
    logic [WIDTH:0]   op_res;

    // Result of one operation, packed as {sout, q}. Modes that do not shift
    // leave sout unchanged.
    function automatic logic [WIDTH:0] apply_op(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic             s,
        input logic             dl,
        input logic             dr,
        input logic [WIDTH-1:0] pd
    );
        logic [WIDTH:0] r;
        r = {s, cur};
        case (m)
            M_HOLD: r = {s, cur};
            M_SHL:  r = {cur[WIDTH-1], cur[WIDTH-2:0], dr};
            M_LSR:  r = {cur[0], dl, cur[WIDTH-1:1]};
            M_ASR:  r = {cur[0], cur[WIDTH-1], cur[WIDTH-1:1]};
            M_ROL:  r = {cur[WIDTH-1], cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:  r = {cur[0], cur[0], cur[WIDTH-1:1]};
            M_LOAD: r = {s, pd};
            M_CLR:  r = {s, {WIDTH{1'b0}}};
            default: r = {s, cur};
        endcase
        return r;
    endfunction

    // Only shifts and rotates can be run as a burst.
    function automatic logic is_shift(input logic [2:0] m);
        return (m >= M_SHL) && (m <= M_ROR);
    endfunction

    // During a burst the latched mode is used, and the current mode input is
    // ignored.
    assign op_res = apply_op((state_q == RUN) ? lmode_q : mode,
                             q_q, sout_q, din_l, din_r, pdata);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        lmode_d = lmode_q;
        done_d  = 1'b0;
        if (en) begin
            if (state_q == RUN) begin
                {sout_d, q_d} = op_res;
                cnt_d         = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else if (start && (len == '0)) begin
                // A zero-length burst only reports completion.
                done_d = 1'b1;
            end else if (start && is_shift(mode)) begin
                {sout_d, q_d} = op_res;
                lmode_d       = mode;
                if (len == CNT_W'(1)) begin
                    done_d = 1'b1;
                end else begin
                    cnt_d   = len - CNT_W'(1);
                    state_d = RUN;
                end
            end else begin
                {sout_d, q_d} = op_res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            lmode_q <= M_HOLD;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            lmode_q <= lmode_d;
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       mode;
    logic             din_l;
    logic             din_r;
    logic [WIDTH-1:0] pdata;
    logic             start;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt;
    int done_cnt;

    shift_reg_univ #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .din_l(din_l), .din_r(din_r), .pdata(pdata),
        .start(start), .len(len),
        .q(q), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        mode  = 3'b110;
        pdata = v;
        start = 1'b0;
        tick();
        mode  = 3'b000;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'b000; din_l = 1'b0; din_r = 1'b0;
        pdata = '0; start = 1'b0; len = '0;
        tick();
        check("rst_q", 32'(q), 32'h00);
        check("rst_sout", 32'(sout), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;
        en  = 1'b1;

        // Load and shift
        load(8'hA5);
        check("load_q", 32'(q), 32'hA5);
        mode = 3'b001; din_r = 1'b1;
        tick();
        check("shl_q", 32'(q), 32'h4B);
        check("shl_sout", 32'(sout), 1);
        mode = 3'b010; din_l = 1'b0; din_r = 1'b0;
        tick();
        check("lsr_q", 32'(q), 32'h25);
        check("lsr_sout", 32'(sout), 1);

        // Arithmetic burst of 3
        load(8'h80);
        mode = 3'b011; len = 3; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        check("asr1_q", 32'(q), 32'hC0);
        check("asr1_busy", 32'(busy), 1);
        check("asr1_done", 32'(done), 0);
        tick();
        check("asr2_q", 32'(q), 32'hE0);
        check("asr2_busy", 32'(busy), 1);
        tick();
        check("asr3_q", 32'(q), 32'hF0);
        check("asr3_busy", 32'(busy), 0);
        check("asr3_done", 32'(done), 1);
        check("asr3_sout", 32'(sout), 0);
        tick();
        check("asr_done_clr", 32'(done), 0);

        // Full rotate left of 8: last bit out is original bit 0 of 0x96 (0)
        load(8'h96);
        mode = 3'b100; len = 8; start = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            start = 1'b0; mode = 3'b000;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check("rol_q", 32'(q), 32'h96);
        check("rol_busy_cycles", 32'(busy_cnt), 7);
        check("rol_done_cycles", 32'(done_cnt), 1);
        check("rol_sout", 32'(sout), 0);

        // Stall and ignore: rotate right 0x01 four times with a 3-cycle stall
        load(8'h01);
        mode = 3'b101; len = 4; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        check("ror1_q", 32'(q), 32'h80);
        tick();
        check("ror2_q", 32'(q), 32'h40);
        en = 1'b0; start = 1'b1; mode = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_q", 32'(q), 32'h40);
            check("stall_busy", 32'(busy), 1);
        end
        en = 1'b1; start = 1'b1; mode = 3'b111;
        tick();
        check("ror3_q", 32'(q), 32'h20);
        check("ror3_busy", 32'(busy), 1);
        check("ror3_done", 32'(done), 0);
        start = 1'b0; mode = 3'b000;
        tick();
        check("ror4_q", 32'(q), 32'h10);
        check("ror4_busy", 32'(busy), 0);
        check("ror4_done", 32'(done), 1);
        check("ror4_sout", 32'(sout), 0);
        tick();

        // Zero-length burst, done clears with en low
        mode = 3'b001; len = 0; start = 1'b1;
        tick();
        start = 1'b0; mode = 3'b000;
        check("zero_done", 32'(done), 1);
        check("zero_q", 32'(q), 32'h10);
        check("zero_busy", 32'(busy), 0);
        en = 1'b0;
        tick();
        check("done_clr_en0", 32'(done), 0);
        en = 1'b1;

        // Hold for 5 cycles
        for (int i = 0; i < 5; i++) tick();
        check("hold_q", 32'(q), 32'h10);
        check("hold_sout", 32'(sout), 0);

        // Reset mid-burst
        load(8'h5A);
        mode = 3'b001; len = 5; start = 1'b1; din_r = 1'b0;
        tick();
        start = 1'b0; mode = 3'b000;
        tick();
        check("pre_rst_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_q", 32'(q), 32'h00);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        #1 rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("post_rst_no_done", 32'(done_cnt), 0);
        check("post_rst_q", 32'(q), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
